// File: rtl/core_frame_receiver_pkg.sv
// Shared sizing constants and receiver state encoding for the core-side
// task dispatch receiver.
package core_frame_receiver_pkg;

  localparam int TM_WIDTH    = 128;
  localparam int INSN_WIDTH  = 16;
  localparam int REG_WIDTH   = 8;
  localparam int FRAME_DEPTH = 8;
  localparam int PC_WIDTH    = 6;

  localparam int SLOTS      = TM_WIDTH / INSN_WIDTH;
  localparam int SLOT_BITS  = $clog2(SLOTS);
  localparam int FRAME_BITS = $clog2(FRAME_DEPTH);
  localparam int CNT_WIDTH  = FRAME_BITS + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_LAUNCH = 2'd2,
    ST_RUN    = 2'd3
  } rx_state_e;

endpackage

// File: rtl/core_frame_receiver_if.sv
// Scheduler-to-core dispatch bundle: frame stream, R0 init and Ready.
// master = scheduler side, slave = core receiver side.
interface core_frame_receiver_if;
  import core_frame_receiver_pkg::*;

  logic                 Start;
  logic [TM_WIDTH-1:0]  Insn_Data;
  logic                 Init_R0_Vect;
  logic [REG_WIDTH-1:0] Init_R0;
  logic                 Ready;

  modport master (output Start, Insn_Data, Init_R0_Vect, Init_R0, input Ready);
  modport slave  (input Start, Insn_Data, Init_R0_Vect, Init_R0, output Ready);
endinterface

// File: rtl/core_frame_receiver_frame_buffer.sv
// Local instruction frame store: one write port, combinational pc-indexed
// instruction read. Contents are deliberately not reset.
module core_frame_receiver_frame_buffer
  import core_frame_receiver_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [FRAME_BITS-1:0] waddr,
  input  logic [TM_WIDTH-1:0]   wdata,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic [INSN_WIDTH-1:0] insn
);

  logic [TM_WIDTH-1:0]   frame_mem [FRAME_DEPTH];
  logic [TM_WIDTH-1:0]   rd_frame;
  logic [INSN_WIDTH-1:0] slot_data [SLOTS];

  always_ff @(posedge clk) begin
    if (we) begin
      frame_mem[waddr] <= wdata;
    end
  end

  assign rd_frame = frame_mem[pc[PC_WIDTH-1:SLOT_BITS]];

  // Slot 0 is the least significant instruction of the frame.
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign slot_data[gi] = rd_frame[gi*INSN_WIDTH +: INSN_WIDTH];
    end
  endgenerate

  assign insn = slot_data[pc[SLOT_BITS-1:0]];

endmodule

// File: rtl/core_frame_receiver.sv
// Core-side receiver: collects a back-to-back frame burst, launches the
// pipeline with the latched R0 init, then holds Ready low until exec_done.
module core_frame_receiver
  import core_frame_receiver_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  core_frame_receiver_if.slave  sched,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic                  exec_done,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  exec_start,
  output logic                  r0_load,
  output logic [REG_WIDTH-1:0]  r0_value,
  output logic [INSN_WIDTH-1:0] insn,
  output logic                  err_overflow,
  output logic                  err_protocol
);

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FRAME_DEPTH);

  rx_state_e              state_reg;
  logic [CNT_WIDTH-1:0]   frame_cnt_reg;
  logic                   ready_reg;
  logic                   exec_start_reg;
  logic                   r0_load_reg;
  logic [REG_WIDTH-1:0]   r0_value_reg;
  logic                   r0_vect_latch_reg;
  logic [REG_WIDTH-1:0]   r0_latch_reg;
  logic                   err_overflow_reg;
  logic                   err_protocol_reg;

  logic                   buf_we;
  logic [FRAME_BITS-1:0]  buf_waddr;

  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = '0;
    if (sched.Start) begin
      if (state_reg == ST_IDLE) begin
        buf_we = 1'b1;
      end else if (state_reg == ST_LOAD && frame_cnt_reg < CNT_FULL) begin
        buf_we    = 1'b1;
        buf_waddr = frame_cnt_reg[FRAME_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= ST_IDLE;
      frame_cnt_reg     <= '0;
      ready_reg         <= 1'b1;
      exec_start_reg    <= 1'b0;
      r0_load_reg       <= 1'b0;
      r0_value_reg      <= '0;
      r0_vect_latch_reg <= 1'b0;
      r0_latch_reg      <= '0;
      err_overflow_reg  <= 1'b0;
      err_protocol_reg  <= 1'b0;
    end else begin
      exec_start_reg <= 1'b0;
      r0_load_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (sched.Start) begin
            frame_cnt_reg     <= CNT_WIDTH'(1);
            r0_vect_latch_reg <= sched.Init_R0_Vect;
            r0_latch_reg      <= sched.Init_R0;
            state_reg         <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (sched.Start) begin
            if (frame_cnt_reg < CNT_FULL) begin
              frame_cnt_reg <= frame_cnt_reg + CNT_WIDTH'(1);
            end else begin
              err_overflow_reg <= 1'b1;
            end
          end else begin
            // First gap cycle closes the burst.
            state_reg      <= ST_LAUNCH;
            ready_reg      <= 1'b0;
            exec_start_reg <= 1'b1;
            r0_load_reg    <= r0_vect_latch_reg;
            r0_value_reg   <= r0_latch_reg;
          end
        end
        ST_LAUNCH: begin
          state_reg <= ST_RUN;
          if (sched.Start) begin
            err_protocol_reg <= 1'b1;
          end
        end
        ST_RUN: begin
          if (sched.Start) begin
            err_protocol_reg <= 1'b1;
          end
          if (exec_done) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  core_frame_receiver_frame_buffer u_frame_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (sched.Insn_Data),
    .pc    (pc),
    .insn  (insn)
  );

  assign sched.Ready  = ready_reg;
  assign frame_cnt    = frame_cnt_reg;
  assign exec_start   = exec_start_reg;
  assign r0_load      = r0_load_reg;
  assign r0_value     = r0_value_reg;
  assign err_overflow = err_overflow_reg;
  assign err_protocol = err_protocol_reg;

endmodule

// File: tb/tb_core_frame_receiver.sv
// Randomized scoreboard bench for core_frame_receiver: stimulus pushes the
// expected launch record, a negedge monitor pops it on every exec_start.
module tb_core_frame_receiver;
  import core_frame_receiver_pkg::*;

  logic                  clk;
  logic                  reset;
  logic [PC_WIDTH-1:0]   pc;
  logic                  exec_done;
  logic [CNT_WIDTH-1:0]  frame_cnt;
  logic                  exec_start;
  logic                  r0_load;
  logic [REG_WIDTH-1:0]  r0_value;
  logic [INSN_WIDTH-1:0] insn;
  logic                  err_overflow;
  logic                  err_protocol;

  core_frame_receiver_if dif ();

  core_frame_receiver dut (
    .clk          (clk),
    .reset        (reset),
    .sched        (dif),
    .pc           (pc),
    .exec_done    (exec_done),
    .frame_cnt    (frame_cnt),
    .exec_start   (exec_start),
    .r0_load      (r0_load),
    .r0_value     (r0_value),
    .insn         (insn),
    .err_overflow (err_overflow),
    .err_protocol (err_protocol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            cnt;
    logic          r0l;
    logic [7:0]    r0v;
  } exp_t;

  exp_t          exp_q[$];
  logic [127:0]  model_mem [8];
  logic          err_ovf_m;
  logic          err_prot_m;
  int            checks;
  int            failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_frame();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference read: frame index from the upper pc bits, 16-bit slot from the low three.
  function automatic logic [15:0] model_insn(input int p);
    logic [127:0] f;
    f = model_mem[p / 8];
    return f[(p % 8) * 16 +: 16];
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1 && exec_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_exec_start", 32'(exec_start), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("launch_frame_cnt", 32'(frame_cnt), 32'(e.cnt));
        check("launch_r0_load", 32'(r0_load), 32'(e.r0l));
        check("launch_r0_value", 32'(r0_value), 32'(e.r0v));
        check("launch_ready", 32'(dif.Ready), 32'd0);
      end
    end
  end

  task automatic run_task(input int n, input logic vect, input logic [7:0] r0,
                          input int run_cycles, input logic start_in_run,
                          input logic done_in_launch, input logic do_reset);
    int   cnt;
    int   p;
    exp_t e;
    logic [127:0] d;
    cnt   = (n > 8) ? 8 : n;
    e.cnt = cnt;
    e.r0l = vect;
    e.r0v = r0;
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      d = rand_frame();
      if (i < 8) model_mem[i] = d;
      if (i >= 8) err_ovf_m = 1'b1;
      check("ready_collect", 32'(dif.Ready), 32'd1);
      dif.Start        = 1'b1;
      dif.Insn_Data    = d;
      dif.Init_R0_Vect = (i == 0) ? vect : 1'($urandom);
      dif.Init_R0      = (i == 0) ? r0 : 8'($urandom);
      step();
    end
    dif.Start     = 1'b0;
    dif.Insn_Data = rand_frame();
    dif.Init_R0   = 8'($urandom);
    check("ready_gap", 32'(dif.Ready), 32'd1);
    step();
    check("latency_exec_start", 32'(exec_start), 32'd1);
    check("ready_launch", 32'(dif.Ready), 32'd0);
    exec_done = done_in_launch;
    step();
    exec_done = 1'b0;
    for (int c = 0; c < run_cycles; c++) begin
      check("ready_run", 32'(dif.Ready), 32'd0);
      check("exec_start_pulse", 32'(exec_start), 32'd0);
      p  = (c == 0 && cnt > 1) ? 8 : int'($urandom_range(cnt * 8 - 1, 0));
      pc = 6'(p);
      #2;
      check("insn_read", 32'(insn), 32'(model_insn(p)));
      if (start_in_run && c == 1) begin
        dif.Start     = 1'b1;
        dif.Insn_Data = rand_frame();
        err_prot_m    = 1'b1;
      end else begin
        dif.Start = 1'b0;
      end
      step();
    end
    dif.Start = 1'b0;
    if (do_reset) begin
      #2;
      reset = 1'b0;
      #1;
      check("areset_ready", 32'(dif.Ready), 32'd1);
      check("areset_exec_start", 32'(exec_start), 32'd0);
      check("areset_r0_load", 32'(r0_load), 32'd0);
      check("areset_r0_value", 32'(r0_value), 32'd0);
      check("areset_frame_cnt", 32'(frame_cnt), 32'd0);
      check("areset_err_ovf", 32'(err_overflow), 32'd0);
      check("areset_err_prot", 32'(err_protocol), 32'd0);
      err_ovf_m  = 1'b0;
      err_prot_m = 1'b0;
      step();
      reset = 1'b1;
      step();
    end else begin
      exec_done = 1'b1;
      check("frame_cnt_hold", 32'(frame_cnt), 32'(cnt));
      step();
      exec_done = 1'b0;
      check("ready_after_done", 32'(dif.Ready), 32'd1);
      check("frame_cnt_idle", 32'(frame_cnt), 32'(cnt));
      check("err_overflow", 32'(err_overflow), 32'(err_ovf_m));
      check("err_protocol", 32'(err_protocol), 32'(err_prot_m));
    end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    err_ovf_m        = 1'b0;
    err_prot_m       = 1'b0;
    reset            = 1'b0;
    pc               = '0;
    exec_done        = 1'b0;
    dif.Start        = 1'b0;
    dif.Insn_Data    = '0;
    dif.Init_R0_Vect = 1'b0;
    dif.Init_R0      = '0;
    repeat (3) step();
    check("reset_ready", 32'(dif.Ready), 32'd1);
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    check("reset_exec_start", 32'(exec_start), 32'd0);
    check("reset_r0_value", 32'(r0_value), 32'd0);
    check("reset_errs", {30'd0, err_overflow, err_protocol}, 32'd0);
    reset = 1'b1;
    step();

    run_task(3, 1'b1, 8'hA5, 4, 1'b0, 1'b0, 1'b0);
    run_task(1, 1'b0, 8'($urandom), 5, 1'b0, 1'b0, 1'b0);
    run_task(10, 1'b1, 8'($urandom), 6, 1'b0, 1'b0, 1'b0);
    run_task(2, 1'b1, 8'($urandom), 4, 1'b1, 1'b0, 1'b0);
    run_task(4, 1'b0, 8'($urandom), 3, 1'b0, 1'b1, 1'b0);
    run_task(5, 1'b1, 8'($urandom), 3, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      run_task(int'($urandom_range(9, 1)), 1'($urandom), 8'($urandom),
               int'($urandom_range(6, 2)), 1'($urandom), 1'($urandom), 1'b0);
    end

    repeat (3) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
